scan_index_gen: RTL
===================

Name: scan_index_gen

Overview:
- Sequential index generator sitting directly upstream of the binary-to-one-hot decoder; its idx output drives the decoder's data input.
- Steps an index through 0..N_OUT-1 (or the reverse) with a programmable dwell per index, skipping masked positions.
- Supports continuous or single-sweep operation; reports index changes, sweep completion and the "nothing to scan" case.

Parameters:
- IDX_W, 3, width of idx; must match the downstream decoder data width.
- N_OUT, 8, number of scan positions; 2 <= N_OUT <= 2**IDX_W.
- PRESCALE_W, 16, width of the dwell period input and internal dwell counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  level-sampled request to begin scanning; acted on only in IDLE.
- stop  input  1  abort scanning; priority over start.
- single  input  1  1 = one sweep then return to IDLE; latched on accepted start.
- dir  input  1  0 = ascending, 1 = descending; latched on accepted start.
- mask  input  N_OUT  1 = skip that index; sampled live at every index selection.
- period  input  PRESCALE_W  dwell length minus 1; sampled at each dwell load.
- idx  output  IDX_W  current scan index, to decoder data.
- idx_valid  output  1  idx is meaningful (high only in RUN).
- step  output  1  one-cycle pulse in the first cycle a new idx is presented.
- sweep_done  output  1  one-cycle pulse when a sweep completes.
- busy  output  1  high in RUN.
- no_target  output  1  one-cycle pulse when start is accepted with all mask bits set.

Behaviour:
- Reset, while rst_n is low and immediately on its assertion:
  - idx = 0; idx_valid, step, sweep_done, busy, no_target all 0.
  - FSM = IDLE; dwell counter = 0.
- FSM has two states, IDLE and RUN. All outputs are registered.
- IDLE, start=1, stop=0, at least one unmasked index:
  - Next cycle: enter RUN.
  - idx = first unmasked index searching from 0 upward (dir=0) or from N_OUT-1 downward (dir=1).
  - idx_valid = 1, busy = 1, step = 1; dwell counter loaded with period.
- IDLE, start=1, stop=0, all mask bits set: stay IDLE; no_target pulses for 1 cycle next cycle.
- IDLE, start=1 and stop=1 together: stay IDLE; no outputs change.
- RUN dwell:
  - Counter decrements each cycle; each index is held for exactly period+1 cycles.
  - Changes to period take effect only at the next load.
- RUN, counter = 0:
  - Select the next unmasked index in the latched direction, wrapping N_OUT-1 -> 0 (up) or 0 -> N_OUT-1 (down).
  - Indices >= N_OUT are never produced.
- Wrap detection: the selected index is <= current (up) or >= current (down); this includes a single unmasked index selecting itself. On wrap, sweep_done pulses in the same cycle the transition takes effect.
  - single = 0: load the new idx, step = 1, reload dwell; sweep_done and step both pulse.
  - single = 1: enter IDLE instead of advancing; idx_valid = 0, busy = 0, idx = 0, step = 0.
- RUN, counter = 0, all indices now masked: enter IDLE (idx_valid = 0, busy = 0, idx = 0) and pulse no_target; no sweep_done.
- Mask change mid-dwell: the current dwell completes regardless of the current index's mask bit.
- RUN, stop = 1 (any cycle, including counter = 0): next cycle IDLE, idx_valid = 0, busy = 0, idx = 0, no step, no sweep_done.
- start while in RUN: ignored; dir and single are not re-latched.
- Search logic: combinational, bounded loop over N_OUT positions; no extra latency beyond the single register stage.

Test Plan:
- N_OUT=8, mask=0, period=2, dir=0, 1-cycle start -> idx 0,1,..,7,0,.. each held 3 cycles; step at every change; sweep_done coincides with the 7->0 change.
- dir=1, mask=8'b0101_0101, period=0, start -> idx sequence 7,5,3,1,7,5,.. one per cycle; sweep_done on every 1->7.
- single=1, mask=0, period=0, start -> idx 0..7 on consecutive cycles; then busy=0, idx_valid=0, idx=0 with a coincident sweep_done pulse; exactly 8 step pulses.
- mask=8'hFF, start -> no_target pulses once, busy stays 0. Separately: while running on idx 2, set mask=8'hFF -> dwell finishes, then IDLE with a no_target pulse.
- Running at idx 4, assert stop for 1 cycle -> next cycle idx_valid=0, busy=0, idx=0. In IDLE, start=stop=1 -> stays IDLE, no pulses.
- Drop rst_n mid-dwell at idx 5, asynchronous to clk -> all outputs 0 before the next clk edge. Release rst_n with start held -> RUN begins on the first edge after release.

Source files
------------

// File: rtl/scan_index_gen_if.sv
// Control/status bundle between a scan requester (master) and scan_index_gen (slave).
// The idx field feeds the downstream binary-to-one-hot decoder data input.
interface scan_index_gen_if #(
  parameter int IDX_W      = 3,
  parameter int N_OUT      = 8,
  parameter int PRESCALE_W = 16
);
  logic                  start;
  logic                  stop;
  logic                  single;
  logic                  dir;
  logic [N_OUT-1:0]      mask;
  logic [PRESCALE_W-1:0] period;
  logic [IDX_W-1:0]      idx;
  logic                  idx_valid;
  logic                  step;
  logic                  sweep_done;
  logic                  busy;
  logic                  no_target;

  modport master (
    output start, stop, single, dir, mask, period,
    input  idx, idx_valid, step, sweep_done, busy, no_target
  );

  modport slave (
    input  start, stop, single, dir, mask, period,
    output idx, idx_valid, step, sweep_done, busy, no_target
  );
endinterface

// File: rtl/scan_index_gen.sv
// Steps an index over 0..N_OUT-1 (or reverse) with programmable dwell, skipping masked
// positions; continuous or single-sweep. All outputs are registered.
module scan_index_gen #(
  parameter int IDX_W      = 3,
  parameter int N_OUT      = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  scan_index_gen_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q;
  logic                  dir_q;
  logic                  single_q;
  logic [PRESCALE_W-1:0] cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  idx_valid_q;
  logic                  step_q;
  logic                  sweep_done_q;
  logic                  busy_q;
  logic                  no_target_q;

  logic                  srch_dir;
  logic [31:0]           base;
  logic [31:0]           pos;
  logic [N_OUT-1:0]      mask_sh;
  logic                  found;
  logic [IDX_W-1:0]      nxt_idx;
  logic                  wrap;

  // In IDLE the search starts one step "before" the first position, so the same
  // walk yields the first unmasked index from 0 up or from N_OUT-1 down.
  always_comb begin
    srch_dir = (state_q == RUN) ? dir_q : bus.dir;
    if (state_q == RUN) base = 32'(idx_q);
    else                base = srch_dir ? 32'd0 : 32'(N_OUT - 1);
    found   = 1'b0;
    nxt_idx = '0;
    pos     = '0;
    mask_sh = '0;
    for (int unsigned k = 1; k <= 32'(N_OUT); k++) begin
      pos     = srch_dir ? (base + 32'(N_OUT) - k) % 32'(N_OUT)
                         : (base + k) % 32'(N_OUT);
      mask_sh = bus.mask >> pos;
      if (!found && !mask_sh[0]) begin
        found   = 1'b1;
        nxt_idx = IDX_W'(pos);
      end
    end
    wrap = dir_q ? (nxt_idx >= idx_q) : (nxt_idx <= idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      single_q     <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      step_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      busy_q       <= 1'b0;
      no_target_q  <= 1'b0;
    end else begin
      step_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      no_target_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            if (found) begin
              state_q     <= RUN;
              dir_q       <= bus.dir;
              single_q    <= bus.single;
              idx_q       <= nxt_idx;
              cnt_q       <= bus.period;
              idx_valid_q <= 1'b1;
              busy_q      <= 1'b1;
              step_q      <= 1'b1;
            end else begin
              no_target_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - PRESCALE_W'(1);
          end else if (!found || (wrap && single_q)) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            idx_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            no_target_q  <= !found;
            sweep_done_q <= found;
          end else begin
            idx_q        <= nxt_idx;
            cnt_q        <= bus.period;
            step_q       <= 1'b1;
            sweep_done_q <= wrap;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.idx        = idx_q;
  assign bus.idx_valid  = idx_valid_q;
  assign bus.step       = step_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.busy       = busy_q;
  assign bus.no_target  = no_target_q;

endmodule
